// File: rtl/chess_turn_controller_pkg.sv
// Shared state encodings and turn constants for the chess clock
// sequencer and the display path that decodes its outputs.
package chess_turn_controller_pkg;

   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_READY = 3'd1,
      ST_RUN_W = 3'd2,
      ST_RUN_B = 3'd3,
      ST_PAUSE = 3'd4,
      ST_OVER  = 3'd5
   } state_t;

   localparam logic TURN_WHITE = 1'b0;
   localparam logic TURN_BLACK = 1'b1;

endpackage

// File: rtl/chess_turn_controller_prescaler.sv
// Free-running divider that produces one TICK per TICK_DIV enabled
// cycles; holds its count while disabled.
module tick_prescaler #(
   parameter int TICK_DIV = 100_000_000
) (
   input  logic CLK,
   input  logic CLR,
   input  logic EN,
   output logic TICK
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] r_cnt;
   logic          w_last;

   assign w_last = (r_cnt == LAST);
   assign TICK   = EN & w_last;

   // divider count: wraps at LAST, frozen when not enabled
   always_ff @(posedge CLK) begin
      if (CLR) begin
         r_cnt <= '0;
      end else if (EN) begin
         r_cnt <= w_last ? '0 : r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/chess_turn_controller.sv
// Chess clock game sequencer: selects the running timer, gates its
// count pulse, and tracks turn, flag fall and completed moves.
module chess_turn_controller
   import chess_turn_controller_pkg::*;
#(
   parameter int TICK_DIV  = 100_000_000,
   parameter int MOVE_W    = 8,
   parameter int MAX_MOVES = 199
) (
   input  logic              CLK,
   input  logic              CLR,
   input  logic              BTN_WHITE,
   input  logic              BTN_BLACK,
   input  logic              BTN_START,
   input  logic              BTN_NEW,
   input  logic              OVF_WHITE,
   input  logic              OVF_BLACK,
   output logic              CE_WHITE,
   output logic              CE_BLACK,
   output logic              IMP_WHITE,
   output logic              IMP_BLACK,
   output logic              CLR_TIMERS,
   output logic              TURN,
   output logic              RUNNING,
   output logic              FLAG_WHITE,
   output logic              FLAG_BLACK,
   output logic [MOVE_W-1:0] MOVES
);

   localparam logic [MOVE_W-1:0] MAX_M = MOVE_W'(MAX_MOVES);

   state_t            r_state;
   state_t            w_next;
   logic              r_btn_w_q;
   logic              r_btn_b_q;
   logic              r_btn_s_q;
   logic              r_btn_n_q;
   logic              r_turn;
   logic              w_turn;
   logic              r_flag_w;
   logic              w_flag_w;
   logic              r_flag_b;
   logic              w_flag_b;
   logic [MOVE_W-1:0] r_moves;
   logic [MOVE_W-1:0] w_moves;
   logic              r_imp_w;
   logic              r_imp_b;
   logic              w_e_w;
   logic              w_e_b;
   logic              w_e_start;
   logic              w_e_new;
   logic              w_run_w;
   logic              w_run_b;
   logic              w_tick;
   logic              w_pre_clr;

   assign w_e_w     = BTN_WHITE & ~r_btn_w_q;
   assign w_e_b     = BTN_BLACK & ~r_btn_b_q;
   assign w_e_start = BTN_START & ~r_btn_s_q;
   assign w_e_new   = BTN_NEW   & ~r_btn_n_q;

   assign w_run_w   = (r_state == ST_RUN_W);
   assign w_run_b   = (r_state == ST_RUN_B);
   assign w_pre_clr = CLR | (r_state == ST_INIT);

   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_pre (
      .CLK  (CLK),
      .CLR  (w_pre_clr),
      .EN   (w_run_w | w_run_b),
      .TICK (w_tick)
   );

   // next state, turn, flags and move count; overflow outranks buttons
   always_comb begin
      w_next   = r_state;
      w_turn   = r_turn;
      w_flag_w = r_flag_w;
      w_flag_b = r_flag_b;
      w_moves  = r_moves;
      unique case (r_state)
         ST_INIT: begin
            w_next   = ST_READY;
            w_turn   = TURN_WHITE;
            w_flag_w = 1'b0;
            w_flag_b = 1'b0;
            w_moves  = '0;
         end
         ST_READY: begin
            if (w_e_start) w_next = ST_RUN_W;
         end
         ST_RUN_W: begin
            if (OVF_WHITE) begin
               w_next   = ST_OVER;
               w_flag_w = 1'b1;
            end else if (w_e_start) begin
               w_next = ST_PAUSE;
            end else if (w_e_w) begin
               w_next = ST_RUN_B;
               w_turn = TURN_BLACK;
            end
         end
         ST_RUN_B: begin
            if (OVF_BLACK) begin
               w_next   = ST_OVER;
               w_flag_b = 1'b1;
            end else if (w_e_start) begin
               w_next = ST_PAUSE;
            end else if (w_e_b) begin
               w_next  = ST_RUN_W;
               w_turn  = TURN_WHITE;
               w_moves = (r_moves >= MAX_M) ? r_moves
                                            : r_moves + MOVE_W'(1);
            end
         end
         ST_PAUSE: begin
            if (w_e_new) begin
               w_next   = ST_INIT;
               w_turn   = TURN_WHITE;
               w_flag_w = 1'b0;
               w_flag_b = 1'b0;
               w_moves  = '0;
            end else if (w_e_start) begin
               w_next = (r_turn == TURN_BLACK) ? ST_RUN_B : ST_RUN_W;
            end
         end
         ST_OVER: begin
            if (w_e_new) begin
               w_next   = ST_INIT;
               w_turn   = TURN_WHITE;
               w_flag_w = 1'b0;
               w_flag_b = 1'b0;
               w_moves  = '0;
            end
         end
         default: begin
            w_next = ST_INIT;
         end
      endcase
   end

   // state, button history and registered count pulses
   always_ff @(posedge CLK) begin
      if (CLR) begin
         r_state   <= ST_INIT;
         r_btn_w_q <= 1'b0;
         r_btn_b_q <= 1'b0;
         r_btn_s_q <= 1'b0;
         r_btn_n_q <= 1'b0;
         r_turn    <= TURN_WHITE;
         r_flag_w  <= 1'b0;
         r_flag_b  <= 1'b0;
         r_moves   <= '0;
         r_imp_w   <= 1'b0;
         r_imp_b   <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_btn_w_q <= BTN_WHITE;
         r_btn_b_q <= BTN_BLACK;
         r_btn_s_q <= BTN_START;
         r_btn_n_q <= BTN_NEW;
         r_turn    <= w_turn;
         r_flag_w  <= w_flag_w;
         r_flag_b  <= w_flag_b;
         r_moves   <= w_moves;
         r_imp_w   <= w_tick & w_run_w;
         r_imp_b   <= w_tick & w_run_b;
      end
   end

   assign CE_WHITE   = w_run_w;
   assign CE_BLACK   = w_run_b;
   assign RUNNING    = w_run_w | w_run_b;
   assign IMP_WHITE  = r_imp_w;
   assign IMP_BLACK  = r_imp_b;
   assign CLR_TIMERS = (r_state == ST_INIT) & ~CLR;
   assign TURN       = r_turn;
   assign FLAG_WHITE = r_flag_w;
   assign FLAG_BLACK = r_flag_b;
   assign MOVES      = r_moves;

endmodule

// File: tb/tb_chess_turn_controller.sv
// Directed bench for chess_turn_controller with an expected-value
// queue; expectations are queued per step and popped after it.
module tb_chess_turn_controller;

   logic       clk;
   logic       clr;
   logic       btn_w;
   logic       btn_b;
   logic       btn_s;
   logic       btn_n;
   logic       ovf_w;
   logic       ovf_b;
   logic       ce_w;
   logic       ce_b;
   logic       imp_w;
   logic       imp_b;
   logic       clr_t;
   logic       turn;
   logic       running;
   logic       flag_w;
   logic       flag_b;
   logic [7:0] moves;

   int total;
   int bad;

   string       sb_tag[$];
   logic [16:0] sb_exp[$];

   chess_turn_controller #(
      .TICK_DIV  (4),
      .MOVE_W    (8),
      .MAX_MOVES (199)
   ) dut (
      .CLK        (clk),
      .CLR        (clr),
      .BTN_WHITE  (btn_w),
      .BTN_BLACK  (btn_b),
      .BTN_START  (btn_s),
      .BTN_NEW    (btn_n),
      .OVF_WHITE  (ovf_w),
      .OVF_BLACK  (ovf_b),
      .CE_WHITE   (ce_w),
      .CE_BLACK   (ce_b),
      .IMP_WHITE  (imp_w),
      .IMP_BLACK  (imp_b),
      .CLR_TIMERS (clr_t),
      .TURN       (turn),
      .RUNNING    (running),
      .FLAG_WHITE (flag_w),
      .FLAG_BLACK (flag_b),
      .MOVES      (moves)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [16:0] ex(
      input logic cew, input logic ceb,
      input logic iw,  input logic ib,
      input logic ct,  input logic tu,
      input logic run, input logic fw,
      input logic fb,  input int mv);
      logic [7:0] m;
      m = mv[7:0];
      return {cew, ceb, iw, ib, ct, tu, run, fw, fb, m};
   endfunction

   function automatic logic [16:0] ob();
      return {ce_w, ce_b, imp_w, imp_b, clr_t, turn,
              running, flag_w, flag_b, moves};
   endfunction

   task automatic push(input string tag, input logic [16:0] e);
      sb_tag.push_back(tag);
      sb_exp.push_back(e);
   endtask

   task automatic pop_check(input logic [16:0] obs);
      string       tag;
      logic [16:0] e;
      total++;
      if (sb_exp.size() == 0) begin
         bad++;
         $display("FAIL sb_empty observed=%h required=entry", obs);
      end else begin
         tag = sb_tag.pop_front();
         e   = sb_exp.pop_front();
         assert (obs === e) else begin
            bad++;
            $error("FAIL %s observed=%h required=%h", tag, obs, e);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press_w();
      btn_w = 1'b1; tick(); btn_w = 1'b0;
   endtask

   task automatic press_b();
      btn_b = 1'b1; tick(); btn_b = 1'b0;
   endtask

   task automatic press_s();
      btn_s = 1'b1; tick(); btn_s = 1'b0;
   endtask

   task automatic press_n();
      btn_n = 1'b1; tick(); btn_n = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      clr   = 1'b1;
      btn_w = 1'b0;
      btn_b = 1'b0;
      btn_s = 1'b0;
      btn_n = 1'b0;
      ovf_w = 1'b0;
      ovf_b = 1'b0;

      // reset and init pulse
      tick();
      tick();
      push("reset_hold", ex(0,0,0,0,0,0,0,0,0,0));
      pop_check(ob());
      clr = 1'b0;
      #1;
      push("init_clr", ex(0,0,0,0,1,0,0,0,0,0));
      pop_check(ob());
      tick();
      push("ready", ex(0,0,0,0,0,0,0,0,0,0));
      pop_check(ob());

      // start: white runs, pulse every 4 cycles
      push("start_w", ex(1,0,0,0,0,0,1,0,0,0));
      press_s();
      pop_check(ob());
      for (int i = 1; i <= 12; i++) begin
         push($sformatf("imp_w_%0d", i),
              ex(1,0,(i % 4 == 0),0,0,0,1,0,0,0));
         tick();
         pop_check(ob());
      end

      // non-mover button and non-running overflow ignored
      push("blk_in_w", ex(1,0,0,0,0,0,1,0,0,0));
      btn_b = 1'b1;
      ovf_b = 1'b1;
      tick();
      btn_b = 1'b0;
      ovf_b = 1'b0;
      pop_check(ob());

      push("sw_to_b", ex(0,1,0,0,0,1,1,0,0,0));
      press_w();
      pop_check(ob());
      push("sw_to_w", ex(1,0,0,0,0,0,1,0,0,1));
      press_b();
      pop_check(ob());
      push("wrap_on_sw", ex(0,1,1,0,0,1,1,0,0,1));
      press_w();
      pop_check(ob());

      // pause holds the prescaler
      push("run_b", ex(0,1,0,0,0,1,1,0,0,1));
      tick();
      pop_check(ob());
      push("pause", ex(0,0,0,0,0,1,0,0,0,1));
      press_s();
      pop_check(ob());
      for (int i = 0; i < 20; i++) begin
         push($sformatf("pause_%0d", i),
              ex(0,0,0,0,0,1,0,0,0,1));
         tick();
         pop_check(ob());
      end
      push("resume_b", ex(0,1,0,0,0,1,1,0,0,1));
      press_s();
      pop_check(ob());
      push("resume_1", ex(0,1,0,0,0,1,1,0,0,1));
      tick();
      pop_check(ob());
      push("resume_imp", ex(0,1,0,1,0,1,1,0,0,1));
      tick();
      pop_check(ob());

      // overflow beats same-cycle button
      push("to_w", ex(1,0,0,0,0,0,1,0,0,2));
      press_b();
      pop_check(ob());
      push("flag_w", ex(0,0,0,0,0,0,0,1,0,2));
      ovf_w = 1'b1;
      btn_w = 1'b1;
      tick();
      ovf_w = 1'b0;
      btn_w = 1'b0;
      pop_check(ob());
      push("over_start", ex(0,0,0,0,0,0,0,1,0,2));
      press_s();
      pop_check(ob());
      push("over_white", ex(0,0,0,0,0,0,0,1,0,2));
      press_w();
      pop_check(ob());
      push("new_init", ex(0,0,0,0,1,0,0,0,0,0));
      press_n();
      pop_check(ob());
      push("new_ready", ex(0,0,0,0,0,0,0,0,0,0));
      tick();
      pop_check(ob());

      // move counter saturation
      push("start2", ex(1,0,0,0,0,0,1,0,0,0));
      press_s();
      pop_check(ob());
      for (int i = 0; i < 200; i++) begin
         press_w();
         press_b();
         if (i >= 197) begin
            push($sformatf("moves_%0d", i + 1),
                 {9'b0, 8'((i + 1 > 199) ? 199 : i + 1)});
            pop_check({9'b0, moves});
         end
      end

      // reset mid RUN_B with START held through release
      push("to_b_sat", {9'b0, 8'd199});
      press_w();
      pop_check({9'b0, moves});
      clr   = 1'b1;
      btn_s = 1'b1;
      push("clr_mid", ex(0,0,0,0,0,0,0,0,0,0));
      tick();
      pop_check(ob());
      clr = 1'b0;
      #1;
      push("clr_init", ex(0,0,0,0,1,0,0,0,0,0));
      pop_check(ob());
      push("held_rdy", ex(0,0,0,0,0,0,0,0,0,0));
      tick();
      pop_check(ob());
      push("held_rdy2", ex(0,0,0,0,0,0,0,0,0,0));
      tick();
      pop_check(ob());
      btn_s = 1'b0;
      tick();
      push("restart", ex(1,0,0,0,0,0,1,0,0,0));
      press_s();
      pop_check(ob());

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
